// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared constants and types for the input debouncer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam logic [15:0] DEB_DEFAULT_THRESHOLD = 16'd20000;
    localparam int unsigned DEB_SYNC_STAGES       = 2;
    localparam int unsigned DEB_CNT_W             = 16;

    // Outcome of one channel's filter decision in a given cycle.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One debounced input: synchroniser, stability counter, level
//               flop and registered rise/fall event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W       = DEB_CNT_W,
    parameter int unsigned SYNC_STAGES = DEB_SYNC_STAGES,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en_i,
    input  logic [CNT_W-1:0] threshold_i,
    input  logic             noisy_i,
    output logic             stable_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_s;
    logic [CNT_W-1:0]       limit;
    edge_e                  edge_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A zero threshold behaves as one; limit is the last count before a flip.
    assign limit = (threshold_i == '0) ? '0 : (threshold_i - CNT_W'(1));

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        edge_d   = EDGE_NONE;
        if (sync_s == stable_q) begin
            cnt_d = '0;
        end else if (sample_en_i) begin
            if (cnt_q >= limit) begin
                stable_d = sync_s;
                cnt_d    = '0;
                edge_d   = sync_s ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q    <= '0;
            stable_q <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], noisy_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= (edge_d == EDGE_RISE);
            fall_q   <= (edge_d == EDGE_FALL);
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule
`default_nettype wire

// File: rtl/multi_channel_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_debouncer
// Description : NUM_CH independent debounced inputs with a shared threshold
//               and sample tick, plus a combined change indication.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = DEB_CNT_W,
    parameter int unsigned SYNC_STAGES = DEB_SYNC_STAGES,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [CNT_W-1:0]  threshold,
    input  logic [NUM_CH-1:0] noisy_in,
    output logic [NUM_CH-1:0] stable_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              any_change
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        debounce_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .sample_en_i (sample_en),
            .threshold_i (threshold),
            .noisy_i     (noisy_in[gi]),
            .stable_o    (stable_out[gi]),
            .rise_o      (rise_pulse[gi]),
            .fall_o      (fall_pulse[gi])
        );
    end

    // Pulses are already registered, so this stays glitch-free.
    assign any_change = |(rise_pulse | fall_pulse);

endmodule
`default_nettype wire
